ahb_prior_aging_ctrl: RTL and testbench

- Per-slave priority scheduler that drives the `hprior` vector of a dynamic-priority AHB slave arbiter.
- Holds a software-programmed base priority per master and ages each waiting requester.
- A master starved for AGE_LIMIT cycles gets a one-level priority boost until it is served.
- Priorities change only at transaction boundaries, so the arbiter never sees a priority change mid-burst.

---
 rtl/ahb_prior_aging_ctrl_pkg.sv | 26 ++
 rtl/ahb_prior_aging_ctrl_prior_age_cell.sv | 126 ++++++++++++
 rtl/ahb_prior_aging_ctrl.sv | 90 +++++++++
 tb/tb_ahb_prior_aging_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_prior_aging_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ahb_prior_aging_ctrl_pkg
// Shared types and helpers for the AHB priority-aging scheduler.
//   prior_state_e  : per-master scheduling state
//   prior_sat_inc  : one-level priority boost that saturates at the top level
// ---------------------------------------------------------------------------
package ahb_prior_aging_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BOOST = 2'd2,
        SERVE = 2'd3
    } prior_state_e;

    // Raises a priority by one level but never past prior_level-1, so a
    // master already at the top level stays there instead of wrapping to 0.
    function automatic int unsigned prior_sat_inc(input int unsigned prior,
                                                  input int unsigned prior_level);
        if (prior + 32'd1 >= prior_level) begin
            return prior_level - 32'd1;
        end
        return prior + 32'd1;
    endfunction

endpackage

// File: rtl/ahb_prior_aging_ctrl_prior_age_cell.sv
// ---------------------------------------------------------------------------
// prior_age_cell
// One master's scheduling state: base-priority register, aging FSM, age
// counter and the effective priority presented to the output stage.
//
// Ports:
//   hclk, hreset_n : clock, synchronous active-low reset
//   hreq           : this master's request to the slave
//   hgrant         : this master's bit of the arbiter grant
//   hwait          : slave wait; a stalled bus does not age requesters
//   xfer_done      : accepted last beat of the granted transaction
//   cfg_we         : base-priority write enable (already decoded)
//   cfg_prior      : base priority to write
//   eff            : effective priority (base, or base+1 saturated in BOOST)
//   boost          : high while in BOOST
//   serve          : high while in SERVE
//
// state | meaning
// IDLE  | no request outstanding
// WAIT  | requesting, not granted, age counting
// BOOST | waited AGE_LIMIT unstalled cycles, priority raised one level
// SERVE | granted; held until the transaction's last beat is accepted
// ---------------------------------------------------------------------------
module prior_age_cell
    import ahb_prior_aging_ctrl_pkg::*;
#(
    parameter int PRIOR_LEVEL = 4,
    parameter int PRIOR_BIT   = $clog2(PRIOR_LEVEL),
    parameter int AGE_LIMIT   = 8,
    parameter int AGE_BIT     = $clog2(AGE_LIMIT + 1)
) (
    input  logic                 hclk,
    input  logic                 hreset_n,
    input  logic                 hreq,
    input  logic                 hgrant,
    input  logic                 hwait,
    input  logic                 xfer_done,
    input  logic                 cfg_we,
    input  logic [PRIOR_BIT-1:0] cfg_prior,
    output logic [PRIOR_BIT-1:0] eff,
    output logic                 boost,
    output logic                 serve
);

    localparam logic [AGE_BIT-1:0] AGE_MAX  = AGE_BIT'(AGE_LIMIT);
    localparam logic [AGE_BIT-1:0] AGE_LAST = AGE_BIT'(AGE_LIMIT - 1);
    localparam logic [AGE_BIT-1:0] AGE_ONE  = AGE_BIT'(1);

    prior_state_e         state;
    prior_state_e         state_nxt;
    logic [AGE_BIT-1:0]   age;
    logic [AGE_BIT-1:0]   age_nxt;
    logic [PRIOR_BIT-1:0] base;

    always_ff @(posedge hclk) begin
        if (!hreset_n) begin
            state <= IDLE;
            age   <= '0;
            base  <= '0;
        end else begin
            state <= state_nxt;
            age   <= age_nxt;
            if (cfg_we) begin
                base <= cfg_prior;
            end
        end
    end

    // Grant is tested before withdrawal in every state so that a grant and a
    // dropped request in the same cycle still lands in SERVE.
    always_comb begin
        state_nxt = state;
        age_nxt   = age;
        case (state)
            IDLE: begin
                age_nxt = '0;
                if (hgrant) begin
                    state_nxt = SERVE;
                end else if (hreq) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (hgrant) begin
                    state_nxt = SERVE;
                    age_nxt   = '0;
                end else if (!hreq) begin
                    state_nxt = IDLE;
                    age_nxt   = '0;
                end else if (!hwait) begin
                    if (age == AGE_LAST) begin
                        state_nxt = BOOST;
                        age_nxt   = AGE_MAX;
                    end else begin
                        age_nxt = age + AGE_ONE;
                    end
                end
            end
            BOOST: begin
                age_nxt = AGE_MAX;
                if (hgrant) begin
                    state_nxt = SERVE;
                    age_nxt   = '0;
                end else if (!hreq) begin
                    state_nxt = IDLE;
                    age_nxt   = '0;
                end
            end
            SERVE: begin
                age_nxt = '0;
                if (xfer_done) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                age_nxt   = '0;
            end
        endcase
    end

    assign boost = (state == BOOST);
    assign serve = (state == SERVE);
    assign eff   = boost ? PRIOR_BIT'(prior_sat_inc(32'(base), PRIOR_LEVEL)) : base;

endmodule

// File: rtl/ahb_prior_aging_ctrl.sv
// ---------------------------------------------------------------------------
// ahb_prior_aging_ctrl
// Drives the hprior vector of a dynamic-priority AHB slave arbiter. Each
// master has a programmable base priority; a requester starved for AGE_LIMIT
// unstalled cycles is boosted one level until served. The output registers
// only update at transaction boundaries so the arbiter never sees a priority
// change in the middle of a burst.
//
// Ports:
//   hclk, hreset_n : clock, synchronous active-low reset
//   hreq           : per-master request to this slave
//   hgrant         : one-hot grant from the arbiter
//   hwait          : slave wait (beat not accepted)
//   xfer_done      : pulse on the accepted last beat of the granted transfer
//   cfg_wr         : base-priority write strobe
//   cfg_idx        : master index for the write (out-of-range ignored)
//   cfg_prior      : base priority to write
//   hprior         : registered effective priority, master i at
//                    [i*PRIOR_BIT +: PRIOR_BIT]
//   starve         : registered per-master boost flag
// ---------------------------------------------------------------------------
module ahb_prior_aging_ctrl
    import ahb_prior_aging_ctrl_pkg::*;
#(
    parameter int MASTER_NUM  = 4,
    parameter int PRIOR_LEVEL = 4,
    parameter int PRIOR_BIT   = $clog2(PRIOR_LEVEL),
    parameter int AGE_LIMIT   = 8,
    parameter int AGE_BIT     = $clog2(AGE_LIMIT + 1)
) (
    input  logic                            hclk,
    input  logic                            hreset_n,
    input  logic [MASTER_NUM-1:0]           hreq,
    input  logic [MASTER_NUM-1:0]           hgrant,
    input  logic                            hwait,
    input  logic                            xfer_done,
    input  logic                            cfg_wr,
    input  logic [$clog2(MASTER_NUM)-1:0]   cfg_idx,
    input  logic [PRIOR_BIT-1:0]            cfg_prior,
    output logic [MASTER_NUM*PRIOR_BIT-1:0] hprior,
    output logic [MASTER_NUM-1:0]           starve
);

    localparam int IDX_BIT = $clog2(MASTER_NUM);

    logic [MASTER_NUM*PRIOR_BIT-1:0] eff_all;
    logic [MASTER_NUM-1:0]           boost_all;
    logic [MASTER_NUM-1:0]           serve_all;
    logic                            freeze;

    // Each cell matches its own index; an index at or beyond MASTER_NUM
    // matches no cell, which is how out-of-range writes are dropped.
    for (genvar i = 0; i < MASTER_NUM; i++) begin : g_cell
        localparam logic [IDX_BIT-1:0] CELL_IDX = IDX_BIT'(i);

        prior_age_cell #(
            .PRIOR_LEVEL (PRIOR_LEVEL),
            .PRIOR_BIT   (PRIOR_BIT),
            .AGE_LIMIT   (AGE_LIMIT),
            .AGE_BIT     (AGE_BIT)
        ) u_cell (
            .hclk      (hclk),
            .hreset_n  (hreset_n),
            .hreq      (hreq[i]),
            .hgrant    (hgrant[i]),
            .hwait     (hwait),
            .xfer_done (xfer_done),
            .cfg_we    (cfg_wr && (cfg_idx == CELL_IDX)),
            .cfg_prior (cfg_prior),
            .eff       (eff_all[i*PRIOR_BIT +: PRIOR_BIT]),
            .boost     (boost_all[i]),
            .serve     (serve_all[i])
        );
    end

    // Hold outputs while a transaction is in flight; the done cycle itself is
    // unfrozen so the pending update lands on the edge that ends the burst.
    assign freeze = (|serve_all) && !xfer_done;

    always_ff @(posedge hclk) begin
        if (!hreset_n) begin
            hprior <= '0;
            starve <= '0;
        end else if (!freeze) begin
            hprior <= eff_all;
            starve <= boost_all;
        end
    end

endmodule

// File: tb/tb_ahb_prior_aging_ctrl.sv
module tb_ahb_prior_aging_ctrl;

    localparam int NM          = 4;
    localparam int PRIOR_LEVEL = 4;
    localparam int AGE_LIMIT   = 8;

    logic       hclk;
    logic       hreset_n;
    logic [3:0] hreq;
    logic [3:0] hgrant;
    logic       hwait;
    logic       xfer_done;
    logic       cfg_wr;
    logic [1:0] cfg_idx;
    logic [1:0] cfg_prior;
    logic [7:0] hprior;
    logic [3:0] starve;
    logic [5:0] hprior3;
    logic [2:0] starve3;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: request bookkeeping per master
    int         m_base [NM];
    int         m_age  [NM];
    bit         m_pend [NM];
    bit         m_serv [NM];
    int         m3_base[3];
    logic [7:0] exp_hprior;
    logic [3:0] exp_starve;
    logic [5:0] exp_h3;

    int owner;
    int beats;
    int pick;

    ahb_prior_aging_ctrl u_dut (
        .hclk      (hclk),
        .hreset_n  (hreset_n),
        .hreq      (hreq),
        .hgrant    (hgrant),
        .hwait     (hwait),
        .xfer_done (xfer_done),
        .cfg_wr    (cfg_wr),
        .cfg_idx   (cfg_idx),
        .cfg_prior (cfg_prior),
        .hprior    (hprior),
        .starve    (starve)
    );

    // three-master instance: cfg_idx 3 is out of range here
    ahb_prior_aging_ctrl #(.MASTER_NUM(3)) u_dut_m3 (
        .hclk      (hclk),
        .hreset_n  (hreset_n),
        .hreq      (3'b000),
        .hgrant    (3'b000),
        .hwait     (1'b0),
        .xfer_done (1'b0),
        .cfg_wr    (cfg_wr),
        .cfg_idx   (cfg_idx),
        .cfg_prior (cfg_prior),
        .hprior    (hprior3),
        .starve    (starve3)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Evaluates the model on the inputs present before the edge, advances one
    // clock, then compares both DUTs against the model 1 time unit later.
    task automatic step();
        bit any_serve;
        bit boosted;
        int e;
        n_tests++;
        assert ($onehot0(hgrant))
        else begin
            n_fail++;
            $error("FAIL grant_onehot: observed 0x%0h expected one-hot or zero", hgrant);
        end
        if (!hreset_n) begin
            for (int i = 0; i < NM; i++) begin
                m_base[i] = 0; m_age[i] = 0; m_pend[i] = 0; m_serv[i] = 0;
            end
            for (int j = 0; j < 3; j++) m3_base[j] = 0;
            exp_hprior = '0;
            exp_starve = '0;
            exp_h3     = '0;
        end else begin
            any_serve = 0;
            for (int i = 0; i < NM; i++) if (m_serv[i]) any_serve = 1;
            if (!(any_serve && !xfer_done)) begin
                for (int i = 0; i < NM; i++) begin
                    boosted = m_pend[i] && (m_age[i] >= AGE_LIMIT);
                    e = m_base[i];
                    if (boosted) e = (m_base[i] + 1 < PRIOR_LEVEL) ? m_base[i] + 1 : PRIOR_LEVEL - 1;
                    exp_hprior[i*2 +: 2] = 2'(e);
                    exp_starve[i]        = boosted;
                end
            end
            for (int j = 0; j < 3; j++) exp_h3[j*2 +: 2] = 2'(m3_base[j]);
            for (int i = 0; i < NM; i++) begin
                if (m_serv[i]) begin
                    if (xfer_done) begin m_serv[i] = 0; m_age[i] = 0; end
                end else if (hgrant[i]) begin
                    m_serv[i] = 1; m_pend[i] = 0; m_age[i] = 0;
                end else if (m_pend[i]) begin
                    if (!hreq[i]) begin
                        m_pend[i] = 0; m_age[i] = 0;
                    end else if (!hwait && m_age[i] < AGE_LIMIT) begin
                        m_age[i]++;
                    end
                end else if (hreq[i]) begin
                    m_pend[i] = 1; m_age[i] = 0;
                end
            end
            if (cfg_wr) begin
                if (int'(cfg_idx) < NM) m_base[cfg_idx] = int'(cfg_prior);
                if (int'(cfg_idx) < 3)  m3_base[cfg_idx] = int'(cfg_prior);
            end
        end
        @(posedge hclk);
        #1;
        chk("hprior", 32'(hprior), 32'(exp_hprior));
        chk("starve", 32'(starve), 32'(exp_starve));
        chk("hprior_m3", 32'(hprior3), 32'(exp_h3));
    endtask

    initial begin
        hreset_n = 1'b0; hreq = 4'hF; hgrant = '0; hwait = 1'b0; xfer_done = 1'b0;
        cfg_wr = 1'b0; cfg_idx = '0; cfg_prior = '0;

        // reset held with all requests up
        step(); step();
        chk("rst_hprior", 32'(hprior), 32'h0);
        chk("rst_starve", 32'(starve), 32'h0);
        hreset_n = 1'b1; hreq = '0;
        step(); step();

        // base write idx 2 = 3
        cfg_wr = 1'b1; cfg_idx = 2'd2; cfg_prior = 2'd3;
        step();
        chk("base2_same_edge", 32'(hprior[5:4]), 32'd0);
        cfg_wr = 1'b0;
        step();
        chk("base2_next", 32'(hprior[5:4]), 32'd3);
        cfg_wr = 1'b1; cfg_idx = 2'd3; cfg_prior = 2'd1;
        step();
        cfg_wr = 1'b0;
        step();
        chk("m3_oob_ignored", 32'(hprior3), 32'h30);
        chk("base3", 32'(hprior[7:6]), 32'd1);

        // aging boost of master 1, base 1
        cfg_wr = 1'b1; cfg_idx = 2'd1; cfg_prior = 2'd1;
        step();
        cfg_wr = 1'b0; hreq = 4'b0010;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 9)  chk("boost_not_yet", 32'(starve[1]), 32'd0);
            if (k == 10) begin
                chk("boost_starve", 32'(starve[1]), 32'd1);
                chk("boost_prior", 32'(hprior[3:2]), 32'd2);
            end
        end
        // saturation at top level
        cfg_wr = 1'b1; cfg_idx = 2'd1; cfg_prior = 2'd3;
        step();
        cfg_wr = 1'b0;
        step();
        chk("boost_sat", 32'(hprior[3:2]), 32'd3);
        hreq = '0;
        step(); step();
        chk("drop_starve1", 32'(starve[1]), 32'd0);

        // hwait stalls aging for 5 cycles
        cfg_wr = 1'b1; cfg_idx = 2'd1; cfg_prior = 2'd1;
        step();
        cfg_wr = 1'b0; hreq = 4'b0010;
        for (int k = 1; k <= 15; k++) begin
            hwait = (k >= 3 && k <= 7);
            step();
            if (k == 14) chk("stall_not_yet", 32'(starve[1]), 32'd0);
            if (k == 15) begin
                chk("stall_boost", 32'(starve[1]), 32'd1);
                chk("stall_prior", 32'(hprior[3:2]), 32'd2);
            end
        end
        hwait = 1'b0; hreq = '0;
        step(); step();

        // mid-burst freeze: master 0 served while 3 and 2 boost
        cfg_wr = 1'b1; cfg_idx = 2'd2; cfg_prior = 2'd2;
        step();
        cfg_wr = 1'b0; hreq = 4'b1101; hgrant = 4'b0001;
        for (int k = 1; k <= 13; k++) begin
            xfer_done = (k == 13);
            step();
            if (k == 12) begin
                chk("frz_prior3", 32'(hprior[7:6]), 32'd1);
                chk("frz_prior2", 32'(hprior[5:4]), 32'd2);
                chk("frz_starve", 32'(starve), 32'h0);
            end
            if (k == 13) begin
                chk("done_prior3", 32'(hprior[7:6]), 32'd2);
                chk("done_prior2", 32'(hprior[5:4]), 32'd3);
                chk("done_starve", 32'(starve), 32'hC);
            end
        end
        // withdrawal of boosted master 2
        hgrant = '0; xfer_done = 1'b0; hreq = 4'b1000;
        step(); step();
        chk("wd_starve", 32'(starve), 32'h8);
        chk("wd_prior2", 32'(hprior[5:4]), 32'd2);
        hreq = '0;
        step(); step();

        // randomized traffic against the model
        owner = -1;
        beats = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            hwait     = ($urandom_range(0, 3) == 0);
            cfg_wr    = ($urandom_range(0, 5) == 0);
            cfg_idx   = 2'($urandom_range(0, 3));
            cfg_prior = 2'($urandom_range(0, 3));
            xfer_done = 1'b0;
            if ($urandom_range(0, 199) == 0) begin
                hreset_n = 1'b0;
                hgrant   = '0;
                owner    = -1;
            end else begin
                hreset_n = 1'b1;
                for (int i = 0; i < NM; i++)
                    if (i != owner && $urandom_range(0, 7) == 0) hreq[i] = ~hreq[i];
                if (owner >= 0) begin
                    hgrant = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'(1 << owner);
                    if (!hwait) begin
                        beats--;
                        if (beats == 0) begin
                            xfer_done = 1'b1;
                            hgrant    = 4'(1 << owner);
                            owner     = -1;
                        end
                    end
                end else if (hreq != '0 && $urandom_range(0, 1) == 0) begin
                    pick = int'($urandom_range(0, 3));
                    while (!hreq[pick]) pick = (pick + 1) % NM;
                    owner  = pick;
                    hgrant = 4'(1 << pick);
                    beats  = int'($urandom_range(1, 6));
                end else begin
                    hgrant    = '0;
                    xfer_done = ($urandom_range(0, 15) == 0);
                end
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
